// File: rtl/axi_rd_burst_engine.sv
// axi_rd_burst_engine
//   AXI read-data channel engine for the memory slave. Decoded read commands are queued in a
//   small FIFO, expanded into per-beat byte addresses (FIXED / INCR / WRAP), issued to a
//   synchronous memory read port (data one cycle after the strobe) and returned on R with full
//   valid/ready backpressure through a 2-entry output buffer.
// Ports
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   cmd_*_i / cmd_ready_o          command from the read-address stage (FIFO write side)
//   mem_rd_en_o, mem_rd_addr_o     memory read strobe and beat byte address
//   mem_rd_data_i                  memory word, valid the cycle after mem_rd_en_o
//   rid_o, rdata_o, rresp_o,
//   rlast_o, rvalid_o, rready_i    AXI R channel
//   busy_o                         commands queued, burst active or beats buffered
module axi_rd_burst_engine #(
    parameter int unsigned ADD_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADD_ID_WIDTH = 4,
    parameter int unsigned LEN_WIDTH    = 8,
    parameter int unsigned CMD_DEPTH    = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADD_WIDTH-1:0]    cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic [2:0]              cmd_size_i,
    input  logic [1:0]              cmd_burst_i,
    input  logic [ADD_ID_WIDTH-1:0] cmd_id_i,
    output logic                    mem_rd_en_o,
    output logic [ADD_WIDTH-1:0]    mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data_i,
    output logic [ADD_ID_WIDTH-1:0] rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic                    busy_o
);
    localparam int unsigned PtrW    = $clog2(CMD_DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned MaxSize = $clog2(DATA_WIDTH / 8);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    typedef struct packed {
        logic [ADD_WIDTH-1:0]    addr;
        logic [LEN_WIDTH-1:0]    len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic [ADD_ID_WIDTH-1:0] id;
    } cmd_t;

    typedef struct packed {
        logic [ADD_ID_WIDTH-1:0] id;
        logic [DATA_WIDTH-1:0]   data;
        logic [1:0]              resp;
        logic                    last;
    } beat_t;

    // ---------------- command FIFO ----------------
    cmd_t          fifo_q [CMD_DEPTH];
    logic [CntW-1:0] wr_ptr_q, rd_ptr_q, fifo_cnt, fifo_cnt_d;
    logic          cmd_ready_q, cmd_push, cmd_pop, fifo_empty;
    cmd_t          head;

    assign cmd_push   = cmd_valid_i && cmd_ready_q;
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_cnt_d = fifo_cnt + CntW'(cmd_push) - CntW'(cmd_pop);
    assign head       = fifo_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            if (cmd_push) wr_ptr_q <= wr_ptr_q + CntW'(1);
            if (cmd_pop)  rd_ptr_q <= rd_ptr_q + CntW'(1);
            cmd_ready_q <= (fifo_cnt_d != CntW'(CMD_DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (cmd_push) begin
            fifo_q[wr_ptr_q[PtrW-1:0]] <= {cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i, cmd_id_i};
        end
    end

    // ---------------- head decode ----------------
    logic [ADD_WIDTH-1:0] head_bytes, head_wrap_mask;
    logic                 head_len_ok, head_err;

    assign head_bytes     = ADD_WIDTH'(1) << head.size;
    assign head_wrap_mask = ((ADD_WIDTH'(head.len) + ADD_WIDTH'(1)) << head.size) - ADD_WIDTH'(1);
    assign head_len_ok    = (head.len == LEN_WIDTH'(1)) || (head.len == LEN_WIDTH'(3)) ||
                            (head.len == LEN_WIDTH'(7)) || (head.len == LEN_WIDTH'(15));
    assign head_err       = (head.burst == 2'b11) || (32'(head.size) > MaxSize) ||
                            ((head.burst == 2'b10) &&
                             (!head_len_ok || ((head.addr & (head_bytes - ADD_WIDTH'(1))) != '0)));

    // ---------------- beat generator ----------------
    state_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [ADD_WIDTH-1:0]    addr_q, addr_d, mask_q, mask_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [ADD_ID_WIDTH-1:0] id_q, id_d;
    logic                    err_q, err_d;

    logic                    issue, issue_err, issue_last, credit;
    logic [ADD_ID_WIDTH-1:0] issue_id;
    logic [ADD_WIDTH-1:0]    cur_addr, cur_mask, cur_bytes, next_addr;
    logic [2:0]              cur_size;
    logic [1:0]              cur_burst;

    // In idle the head of the FIFO is issued directly, so LOAD and first ISSUE share a cycle.
    assign cur_addr  = (state_q == StIdle) ? head.addr      : addr_q;
    assign cur_mask  = (state_q == StIdle) ? head_wrap_mask : mask_q;
    assign cur_size  = (state_q == StIdle) ? head.size      : size_q;
    assign cur_burst = (state_q == StIdle) ? head.burst     : burst_q;
    assign cur_bytes = ADD_WIDTH'(1) << cur_size;

    always_comb begin
        case (cur_burst)
            2'b00:   next_addr = cur_addr;
            2'b10:   next_addr = (cur_addr & ~cur_mask) | ((cur_addr + cur_bytes) & cur_mask);
            default: next_addr = (cur_addr & ~(cur_bytes - ADD_WIDTH'(1))) + cur_bytes;
        endcase
    end

    // Output buffer state, needed for credit.
    logic [1:0] buf_cnt_q;
    logic       pipe_v_q, rvalid, r_pop;
    logic [2:0] occ;

    // Beats buffered plus beats in flight, minus the one leaving this cycle, must stay below 2.
    assign occ    = 3'(buf_cnt_q) + 3'(pipe_v_q) - 3'(r_pop);
    assign credit = (occ < 3'd2);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        size_d     = size_q;
        burst_d    = burst_q;
        id_d       = id_q;
        err_d      = err_q;
        cmd_pop    = 1'b0;
        issue      = 1'b0;
        issue_err  = err_q;
        issue_last = 1'b0;
        issue_id   = id_q;
        case (state_q)
            StIdle: begin
                if (!fifo_empty && credit) begin
                    cmd_pop    = 1'b1;
                    issue      = 1'b1;
                    issue_err  = head_err;
                    issue_last = (head.len == '0);
                    issue_id   = head.id;
                    addr_d     = next_addr;
                    mask_d     = head_wrap_mask;
                    size_d     = head.size;
                    burst_d    = head.burst;
                    id_d       = head.id;
                    err_d      = head_err;
                    rem_d      = head.len;
                    if (head.len != '0) state_d = StIssue;
                end
            end
            StIssue: begin
                if (credit) begin
                    issue      = 1'b1;
                    issue_last = (rem_q == LEN_WIDTH'(1));
                    addr_d     = next_addr;
                    rem_d      = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            rem_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    // Error beats travel the same pipeline as reads but never strobe the memory.
    assign mem_rd_en_o   = issue && !issue_err;
    assign mem_rd_addr_o = cur_addr;

    // ---------------- read pipeline and output buffer ----------------
    logic                    pipe_err_q, pipe_last_q;
    logic [ADD_ID_WIDTH-1:0] pipe_id_q;
    logic [DATA_WIDTH-1:0]   pipe_data;
    beat_t                   pipe_beat, head_beat;
    beat_t                   buf_q [2];
    logic                    buf_rd_q, buf_wr_q, buf_nonempty, buf_push, buf_pop;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pipe_v_q    <= 1'b0;
            pipe_err_q  <= 1'b0;
            pipe_last_q <= 1'b0;
            pipe_id_q   <= '0;
        end else begin
            pipe_v_q    <= issue;
            pipe_err_q  <= issue_err;
            pipe_last_q <= issue_last;
            pipe_id_q   <= issue_id;
        end
    end

    assign pipe_data = pipe_err_q ? '0 : mem_rd_data_i;
    assign pipe_beat = '{id: pipe_id_q, data: pipe_data,
                         resp: (pipe_err_q ? 2'b10 : 2'b00), last: pipe_last_q};

    // An empty buffer is bypassed so returning data is visible in the cycle it arrives.
    assign buf_nonempty = (buf_cnt_q != 2'd0);
    assign rvalid       = buf_nonempty || pipe_v_q;
    assign r_pop        = rvalid && rready_i;
    assign head_beat    = buf_nonempty ? buf_q[buf_rd_q] : pipe_beat;
    assign buf_push     = pipe_v_q && (buf_nonempty || !rready_i);
    assign buf_pop      = r_pop && buf_nonempty;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buf_cnt_q <= 2'd0;
            buf_rd_q  <= 1'b0;
            buf_wr_q  <= 1'b0;
        end else begin
            buf_cnt_q <= buf_cnt_q + 2'(buf_push) - 2'(buf_pop);
            if (buf_push) buf_wr_q <= ~buf_wr_q;
            if (buf_pop)  buf_rd_q <= ~buf_rd_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_push) buf_q[buf_wr_q] <= pipe_beat;
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rvalid_o    = rvalid;
    assign rid_o       = rvalid ? head_beat.id   : '0;
    assign rdata_o     = rvalid ? head_beat.data : '0;
    assign rresp_o     = rvalid ? head_beat.resp : 2'b00;
    assign rlast_o     = rvalid && head_beat.last;
    assign busy_o      = !fifo_empty || (state_q == StIssue) || pipe_v_q || buf_nonempty;

endmodule
